// File: rtl/core_hazard_pkg.sv
// Shared definitions for the 5-stage core hazard logic: stage indices,
// stall cause codes, per-stage hold/bubble masks and the controller FSM states.
package core_hazard_pkg;

    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;
    localparam int NUM_STAGES = 5;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_CACHE   = 3'd1,
        CAUSE_BUSY    = 3'd2,
        CAUSE_BRANCH  = 3'd3,
        CAUSE_LOADUSE = 3'd4
    } cause_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MISS  = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    // Bit i of each mask is stage i (IF in the LSB).
    localparam logic [NUM_STAGES-1:0] MASK_ALL   = 5'b11111;
    localparam logic [NUM_STAGES-1:0] MASK_IF_EX = 5'b00111;
    localparam logic [NUM_STAGES-1:0] MASK_IF_ID = 5'b00011;
    localparam logic [NUM_STAGES-1:0] MASK_EX    = 5'b00100;
    localparam logic [NUM_STAGES-1:0] MASK_MEM   = 5'b01000;

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Load-use detector: a load in EX whose destination matches any live ID source.
// Register 0 is hard-wired, so it never creates a dependency.
module hazard_loaduse_cmp #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic [NUM_SRC-1:0]            id_src_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr_i,
    input  logic                          ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0]         ex_rd_i,
    output logic                          load_use_o
);

    logic src_hit;

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid_i[i] && (id_src_addr_i[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd_i)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) && src_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage hold/bubble vectors by fixed priority,
// branch-flush sequencer that survives cache misses, miss timeout and stall counter.
module hazard_ctrl
    import core_hazard_pkg::*;
#(
    parameter int NUM_CACHE    = 2,
    parameter int NUM_SRC      = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int BR_PENALTY   = 2,
    parameter int MISS_TIMEOUT = 256,
    parameter int CNT_W        = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CACHE-1:0]          cache_ready,
    input  logic [NUM_SRC-1:0]            id_src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_branch_taken,
    input  logic                          ex_busy,
    input  logic                          cnt_clr,
    input  logic                          err_clr,
    output logic [NUM_STAGES-1:0]         stall_o,
    output logic [NUM_STAGES-1:0]         flush_o,
    output logic                          stall,
    output logic [2:0]                    cause_o,
    output logic [CNT_W-1:0]              stall_cnt_o,
    output logic                          timeout_err_o
);

    localparam int FC_W = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
    localparam int MC_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MC_W-1:0] MISS_LIMIT = MC_W'(MISS_TIMEOUT);
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(BR_PENALTY - 1);

    hz_state_e       state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [MC_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            err_q, err_d;

    logic            cache_miss;
    logic            load_use;
    logic            flush_pending;
    logic [NUM_STAGES-1:0] stall_v, flush_v;
    cause_e          cause_v;

    hazard_loaduse_cmp #(
        .NUM_SRC    (NUM_SRC),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_loaduse (
        .id_src_valid_i (id_src_valid),
        .id_src_addr_i  (id_src_addr),
        .ex_mem_read_i  (ex_mem_read),
        .ex_rd_i        (ex_rd),
        .load_use_o     (load_use)
    );

    assign cache_miss = ~&cache_ready;
    // Flush cycles still owed; also true in MISS so the first ready cycle resumes flushing.
    assign flush_pending = (state_q != RUN) && (flush_cnt_q != '0);

    always_comb begin
        stall_v = '0;
        flush_v = '0;
        cause_v = CAUSE_NONE;
        if (!rst_n) begin
            cause_v = CAUSE_NONE;
        end else if (cache_miss) begin
            stall_v = MASK_ALL;
            cause_v = CAUSE_CACHE;
        end else if (ex_busy) begin
            stall_v = MASK_IF_EX;
            flush_v = MASK_MEM;
            cause_v = CAUSE_BUSY;
        end else if (ex_branch_taken || flush_pending) begin
            flush_v = MASK_IF_ID;
            cause_v = CAUSE_BRANCH;
        end else if (load_use) begin
            stall_v = MASK_IF_ID;
            flush_v = MASK_EX;
            cause_v = CAUSE_LOADUSE;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (cache_miss) begin
            state_d = MISS;
        end else if (ex_busy) begin
            if (state_q == MISS) begin
                state_d = (flush_cnt_q != '0) ? FLUSH : RUN;
            end
        end else if (ex_branch_taken) begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = (BR_PENALTY > 1) ? FLUSH : RUN;
        end else if (flush_pending) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
            state_d     = (flush_cnt_q == FC_W'(1)) ? RUN : FLUSH;
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        miss_cnt_d = '0;
        if (cache_miss) begin
            miss_cnt_d = (miss_cnt_q == MISS_LIMIT) ? miss_cnt_q : miss_cnt_q + 1'b1;
        end
        err_d = err_q;
        if (cache_miss && (miss_cnt_d == MISS_LIMIT)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if ((stall_v != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_o       = stall_v;
    assign flush_o       = flush_v;
    assign stall         = |stall_v;
    assign cause_o       = cause_v;
    assign stall_cnt_o   = stall_cnt_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a cycle-level behavioural
// model that tracks owed flush cycles, miss run length, error flag and stall count.
module tb_hazard_ctrl;

  localparam int NC  = 2;
  localparam int NS  = 2;
  localparam int AW  = 5;
  localparam int BRP = 3;
  localparam int MT  = 256;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0]    cache_ready;
  logic [NS-1:0]    id_src_valid;
  logic [NS*AW-1:0] id_src_addr;
  logic             ex_mem_read;
  logic [AW-1:0]    ex_rd;
  logic             ex_branch_taken;
  logic             ex_busy;
  logic             cnt_clr;
  logic             err_clr;
  logic [4:0]       stall_o;
  logic [4:0]       flush_o;
  logic             stall;
  logic [2:0]       cause_o;
  logic [CW-1:0]    stall_cnt_o;
  logic             timeout_err_o;

  int checks   = 0;
  int failures = 0;

  // model state
  int            pending;
  int            miss_run;
  logic          m_err;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NUM_CACHE    (NC),
    .NUM_SRC      (NS),
    .REG_ADDR_W   (AW),
    .BR_PENALTY   (BRP),
    .MISS_TIMEOUT (MT),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cache_ready     (cache_ready),
    .id_src_valid    (id_src_valid),
    .id_src_addr     (id_src_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_busy         (ex_busy),
    .cnt_clr         (cnt_clr),
    .err_clr         (err_clr),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .stall           (stall),
    .cause_o         (cause_o),
    .stall_cnt_o     (stall_cnt_o),
    .timeout_err_o   (timeout_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pending  = 0;
    miss_run = 0;
    m_err    = 1'b0;
    m_cnt    = '0;
  endtask

  function automatic bit ref_load_use();
    bit hit = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (id_src_valid[i] && (id_src_addr[i*AW +: AW] == ex_rd)) hit = 1'b1;
    end
    return hit && ex_mem_read && (ex_rd != 0);
  endfunction

  task automatic expect_outs(output logic [4:0] es, output logic [4:0] ef, output logic [2:0] ec);
    es = 5'b00000; ef = 5'b00000; ec = 3'd0;
    if (!rst_n) begin
      ec = 3'd0;
    end else if (cache_ready != {NC{1'b1}}) begin
      es = 5'b11111; ec = 3'd1;
    end else if (ex_busy) begin
      es = 5'b00111; ef = 5'b01000; ec = 3'd2;
    end else if (ex_branch_taken || pending > 0) begin
      ef = 5'b00011; ec = 3'd3;
    end else if (ref_load_use()) begin
      es = 5'b00011; ef = 5'b00100; ec = 3'd4;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] es, ef;
    logic [2:0] ec;
    expect_outs(es, ef, ec);
    chk({tag, ".stall_o"}, 32'(stall_o), 32'(es));
    chk({tag, ".flush_o"}, 32'(flush_o), 32'(ef));
    chk({tag, ".stall"}, 32'(stall), 32'(es != 0));
    chk({tag, ".cause_o"}, 32'(cause_o), 32'(ec));
    chk({tag, ".stall_cnt_o"}, stall_cnt_o, m_cnt);
    chk({tag, ".timeout_err_o"}, 32'(timeout_err_o), 32'(m_err));
  endtask

  task automatic model_clock();
    logic [4:0] es, ef;
    logic [2:0] ec;
    bit miss;
    if (!rst_n) begin
      model_reset();
      return;
    end
    expect_outs(es, ef, ec);
    miss = (cache_ready != {NC{1'b1}});
    if (miss) begin
      if (miss_run < MT) miss_run++;
    end else begin
      miss_run = 0;
    end
    if (!miss && !ex_busy) begin
      if (ex_branch_taken) pending = BRP - 1;
      else if (pending > 0) pending--;
    end
    if (miss && miss_run == MT) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (cnt_clr) m_cnt = '0;
    else if (es != 0 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
  endtask

  // Inputs are set by the caller just after a rising edge; outputs are checked on the falling edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    cache_ready     = {NC{1'b1}};
    id_src_valid    = '0;
    id_src_addr     = '0;
    ex_mem_read     = 1'b0;
    ex_rd           = '0;
    ex_branch_taken = 1'b0;
    ex_busy         = 1'b0;
    cnt_clr         = 1'b0;
    err_clr         = 1'b0;
  endtask

  task automatic set_load_use(input logic [AW-1:0] rd);
    ex_mem_read  = 1'b1;
    ex_rd        = rd;
    id_src_valid = 2'b01;
    id_src_addr  = {5'd9, 5'd5};
  endtask

  initial begin
    model_reset();
    idle();
    rst_n       = 1'b0;
    cache_ready = 2'b00;
    ex_busy     = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    repeat (2) step("in_reset");
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_reset_idle");

    // load-use hit, then ex_rd = 0 must not hazard
    set_load_use(5'd5);
    step("loaduse_hit");
    chk("loaduse_hit.direct_cause", 32'(cause_o), 32'd4);
    set_load_use(5'd0);
    id_src_addr = '0;
    step("loaduse_rd0");
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_src_valid = 2'b10; id_src_addr = {5'd7, 5'd3};
    step("loaduse_src1");
    id_src_valid = 2'b01;
    step("loaduse_src1_invalid");

    // branch flush for BRP cycles
    idle();
    ex_branch_taken = 1'b1;
    step("br_pulse");
    ex_branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("br_tail%0d", i));
    chk("br_done.flush_o", 32'(flush_o), 32'd0);

    // branch interrupted by a 4-cycle miss
    ex_branch_taken = 1'b1;
    step("brmiss_pulse");
    ex_branch_taken = 1'b0;
    cache_ready = 2'b10;
    for (int i = 0; i < 4; i++) step($sformatf("brmiss_miss%0d", i));
    cache_ready = 2'b11;
    for (int i = 0; i < 3; i++) step($sformatf("brmiss_resume%0d", i));

    // priority: everything at once, then drop the miss
    cache_ready = 2'b10; ex_busy = 1'b1; ex_branch_taken = 1'b1;
    set_load_use(5'd5);
    step("prio_all");
    cache_ready = 2'b11;
    step("prio_busy");
    idle();
    for (int i = 0; i < 2; i++) step($sformatf("prio_after%0d", i));

    // miss timeout
    cache_ready = 2'b10;
    for (int i = 0; i < MT; i++) step("timeout_run");
    cache_ready = 2'b11;
    step("timeout_set");
    chk("timeout_set.direct", 32'(timeout_err_o), 32'd1);
    step("timeout_sticky");
    err_clr = 1'b1;
    step("timeout_clr");
    err_clr = 1'b0;
    step("timeout_cleared");

    // counter clear
    cnt_clr = 1'b1;
    step("cnt_clr");
    cnt_clr = 1'b0;
    step("cnt_after_clr");

    // async reset in the middle of a flush
    ex_branch_taken = 1'b1;
    step("rst_br");
    ex_branch_taken = 1'b0;
    ex_busy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.flush_o", 32'(flush_o), 32'd0);
    chk("async_rst.stall_o", 32'(stall_o), 32'd0);
    chk("async_rst.cause_o", 32'(cause_o), 32'd0);
    chk("async_rst.stall_cnt_o", stall_cnt_o, 32'd0);
    @(posedge clk); #1;
    step("rst_hold");
    rst_n = 1'b1;
    step("rst_release");
    step("rst_release2");

    // random traffic
    for (int n = 0; n < 500; n++) begin
      cache_ready     = ($urandom_range(0, 7) == 0) ? NC'($urandom_range(0, 3)) : {NC{1'b1}};
      ex_busy         = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_read     = $urandom_range(0, 1);
      ex_rd           = AW'($urandom_range(0, 7));
      id_src_valid    = NS'($urandom_range(0, 3));
      id_src_addr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      cnt_clr         = ($urandom_range(0, 49) == 0);
      err_clr         = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage core (IF, ID, EX, MEM, WB). It replaces the single aggregate stall flag with per-stage hold and bubble (flush) vectors, and detects load-use hazards internally from register addresses. It adds a multi-cycle branch-flush sequencer, multi-port cache-miss wait tracking with timeout, and a stall performance counter. It sits beside the pipeline registers and drives their enable and clear inputs.

Parameters:
NUM_CACHE, 2, number of cache ports with ready flags (I$ and D$).
NUM_SRC, 2, number of ID-stage source operands checked for load-use.
REG_ADDR_W, 5, register address width.
BR_PENALTY, 2, number of cycles IF/ID are flushed after a taken branch; must be ≥1.
MISS_TIMEOUT, 256, consecutive not-ready cycles that set the timeout error.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
cache_ready  in  NUM_CACHE  1 = cache port ready
id_src_valid  in  NUM_SRC  ID operand i is used
id_src_addr  in  NUM_SRC*REG_ADDR_W  ID source addresses, packed, operand 0 in the LSBs
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_ADDR_W  EX destination register
ex_branch_taken  in  1  taken-branch/redirect pulse from EX
ex_busy  in  1  multi-cycle EX unit not done
cnt_clr  in  1  synchronous clear of stall_cnt_o
err_clr  in  1  synchronous clear of timeout_err_o
stall_o  out  5  per-stage hold; bit 0 = IF … bit 4 = WB
flush_o  out  5  per-stage bubble insert; same bit order
stall  out  1  OR of stall_o (legacy aggregate)
cause_o  out  3  current cause: 0 none, 1 cache, 2 busy, 3 branch, 4 load-use
stall_cnt_o  out  CNT_W  cycles with stall asserted
timeout_err_o  out  1  sticky miss-timeout flag

Behaviour:
- Reset (rst_n low, async): FSM to RUN; flush counter, miss counter and stall_cnt_o to 0; timeout_err_o = 0. While rst_n is low, stall_o, flush_o, stall and cause_o = 0.
- Timing: stall_o, flush_o and cause_o are combinational from the current state and inputs, with 0-cycle latency. All counters and the FSM update on the rising edge of clk.
- load_use = ex_mem_read & (ex_rd != 0) & OR over i of (id_src_valid[i] & id_src_addr[i] == ex_rd).
- Fixed priority, highest first:
  1. Cache miss: any cache_ready bit = 0. stall_o = 5'b11111, flush_o = 0, cause 1.
  2. Busy: ex_busy. stall_o = 5'b00111, flush_o = 5'b01000, cause 2. ex_branch_taken is ignored in this cycle.
  3. Branch: ex_branch_taken, or FSM in FLUSH. flush_o = 5'b00011, stall_o = 0, cause 3. Any load_use is ignored.
  4. Load-use: stall_o = 5'b00011, flush_o = 5'b00100, cause 4.
  5. Otherwise all outputs 0.
- FSM states and transitions:
  - RUN:
    - Cache miss → MISS.
    - Taken branch (not masked by cache miss or busy) with BR_PENALTY > 1 → FLUSH, flush counter = BR_PENALTY-1.
  - FLUSH:
    - Flush counter decrements once per non-stalled cycle; 1→0 → RUN.
    - A new ex_branch_taken reloads the counter to BR_PENALTY-1.
    - Cache miss → MISS, with the flush counter held. flush_o is 0 while in MISS.
  - MISS:
    - On all cache_ready bits = 1 → FLUSH if flush counter ≠ 0, else RUN.
- Miss counter:
  - Increments each cycle in which a cache miss is present and saturates at MISS_TIMEOUT.
  - Cleared on any cycle in which all cache ports are ready.
  - Reaching MISS_TIMEOUT sets timeout_err_o, which stays set until err_clr or reset. If err_clr coincides with a set condition, set wins.
- stall_cnt_o: +1 each cycle stall = 1. Saturates at all-ones, no wrap. cnt_clr has priority over increment.
- ex_rd = 0 never produces a load-use hazard.

Decomposition:
- Shared package core_hazard_pkg holds:
  - stage index constants: STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4, NUM_STAGES=5
  - cause encodings CAUSE_NONE … CAUSE_LOADUSE
  - FSM state typedef {RUN, MISS, FLUSH}
- One sub-module: hazard_loaduse_cmp, the parametrised NUM_SRC comparator producing load_use.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_src_addr[0]=5, valid=1 → same cycle stall_o=00011, flush_o=00100, cause_o=4; with ex_rd=0 → all outputs 0.
- ex_branch_taken pulse with BR_PENALTY=3 → flush_o=00011 for exactly 3 cycles, then 0; cause_o=3 throughout the 3 cycles.
- Branch pulse, then cache_ready=2'b10 for 4 cycles after the first flush cycle → stall_o=11111 and flush_o=0 for 4 cycles, then 2 remaining flush cycles; stall_cnt_o grows by 4.
- Simultaneous cache miss, ex_busy, branch and load-use → cause_o=1; drop the cache miss → cause_o=2 and the branch is ignored.
- cache_ready[0]=0 held for 256 cycles (MISS_TIMEOUT=256) → timeout_err_o rises after the 256th cycle and stays set after ready returns; err_clr clears it.
- rst_n asserted low mid-FLUSH → all outputs 0 immediately; after release, FSM in RUN and stall_cnt_o=0.
